// File: rtl/popcount_seq_ctrl_pkg.sv
// Shared types and defaults for the popcount sequencer: FSM state encoding and default slice width.
package popcount_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W_DEF = 8;

    function automatic int idx_width(input int n_slc);
        return (n_slc > 1) ? $clog2(n_slc) : 1;
    endfunction

endpackage

// File: rtl/popcount_seq_ctrl_slice_popcount.sv
// Combinational popcount of one SLICE_W-bit slice; zero latency, no flow control.
module slice_popcount
    import popcount_seq_ctrl_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int PC_W    = $clog2(SLICE_W + 1)
) (
    input  logic [SLICE_W-1:0] slice,
    output logic [PC_W-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            count = count + PC_W'(slice[i]);
        end
    end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Multi-cycle popcount: one shared slice counter walks the word, result after WORD_W/SLICE_W edges.
// Single word in flight; in_ready only in IDLE, result held in registers until out_ready.
module popcount_seq_ctrl
    import popcount_seq_ctrl_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_zero,
    output logic              out_all_ones,
    output logic              busy
);

    localparam int N_SLC = WORD_W / SLICE_W;
    localparam int IDX_W = idx_width(N_SLC);
    localparam int PC_W  = $clog2(SLICE_W + 1);

    if (WORD_W % SLICE_W != 0) begin : g_bad_width
        $error("popcount_seq_ctrl: WORD_W must be a multiple of SLICE_W");
    end

    state_t                           state;
    logic [N_SLC-1:0][SLICE_W-1:0]    word_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [CNT_W-1:0]                 acc_q;
    logic [PC_W-1:0]                  slice_cnt;
    logic [CNT_W-1:0]                 acc_next;

    slice_popcount #(
        .SLICE_W (SLICE_W),
        .PC_W    (PC_W)
    ) u_slice (
        .slice (word_q[idx_q]),
        .count (slice_cnt)
    );

    assign acc_next = acc_q + CNT_W'(slice_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_zero     <= 1'b0;
            out_all_ones <= 1'b0;
            busy         <= 1'b0;
        end else if (abort) begin
            // Abort outranks any handshake, including an accept in IDLE.
            state        <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_zero     <= 1'b0;
            out_all_ones <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_q   <= in_data;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_SLC - 1)) begin
                        state        <= ST_DONE;
                        out_valid    <= 1'b1;
                        out_count    <= acc_next;
                        out_zero     <= (acc_next == '0);
                        out_all_ones <= (acc_next == CNT_W'(WORD_W));
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state        <= ST_IDLE;
                        out_valid    <= 1'b0;
                        out_zero     <= 1'b0;
                        out_all_ones <= 1'b0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed and randomized checks of popcount_seq_ctrl against a bit-loop reference model.
module tb_popcount_seq_ctrl;

    localparam int N_RAND = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_count;
    logic        out_zero;
    logic        out_all_ones;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    popcount_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_zero     (out_zero),
        .out_all_ones (out_all_ones),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pop(input logic [31:0] w);
        int c = 0;
        for (int i = 0; i < 32; i++) if (w[i]) c++;
        return c;
    endfunction

    // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic run_word(input string tag, input logic [31:0] d, input int exp_cnt, input int hold);
        int lat;
        in_valid = 1'b1;
        in_data  = d;
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({tag, "_run_rdy"}, 32'(in_ready), 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_vld"}, 32'(out_valid), 1);
        chk({tag, "_count"}, 32'(out_count), exp_cnt);
        chk({tag, "_zero"}, 32'(out_zero), (exp_cnt == 0) ? 1 : 0);
        chk({tag, "_ones"}, 32'(out_all_ones), (exp_cnt == 32) ? 1 : 0);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_vld"}, 32'(out_valid), 1);
            chk({tag, "_hold_cnt"}, 32'(out_count), exp_cnt);
            chk({tag, "_hold_rdy"}, 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_vld"}, 32'(out_valid), 0);
        chk({tag, "_post_rdy"}, 32'(in_ready), 1);
        chk({tag, "_post_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int cyc;
        int e;
        int q[$];
        logic stalled;
        logic [5:0] prev_cnt;
        logic [31:0] pat;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(out_count), 0);
        chk("rst_zero", 32'(out_zero), 0);
        chk("rst_ones", 32'(out_all_ones), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_word("zero", 32'h0000_0000, 0, 0);
        run_word("ones", 32'hFFFF_FFFF, 32, 0);
        run_word("two", 32'h8000_0001, 2, 0);
        run_word("stall", 32'hF0F0_0F01, 13, 5);

        // Abort on the second RUN edge.
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rdy", 32'(in_ready), 1);
        chk("abort_vld", 32'(out_valid), 0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_vld", 32'(out_valid), 0);
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0F0F_0F0F;
        @(posedge clk);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_no_accept", 32'(busy), 0);
        run_word("after_abort", 32'h0000_00FF, 8, 0);

        // Asynchronous reset in the middle of RUN.
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(in_ready), 1);
        chk("arst_vld", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("arst_no_vld", 32'(out_valid), 0);
        end
        run_word("after_rst", 32'h1234_5678, 13, 0);

        // Random back-to-back traffic with random consumer backpressure.
        sent = 0;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_cnt = '0;
        while (got < N_RAND && cyc < 20000) begin
            if (out_valid && stalled) chk("rand_stable", 32'(out_count), 32'(prev_cnt));
            if (out_valid) chk("rand_rdy_done", 32'(in_ready), 0);
            case ($urandom_range(0, 7))
                0:       pat = 32'h0000_0000;
                1:       pat = 32'hFFFF_FFFF;
                default: pat = $urandom;
            endcase
            in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            in_data   = pat;
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                q.push_back(ref_pop(in_data));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_dup", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rand_count", 32'(out_count), e);
                    chk("rand_zero", 32'(out_zero), (e == 0) ? 1 : 0);
                    chk("rand_ones", 32'(out_all_ones), (e == 32) ? 1 : 0);
                end
                got++;
            end
            stalled  = out_valid && !out_ready;
            prev_cnt = out_count;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_got", got, N_RAND);
        chk("rand_leftover", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
